// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the LIFO stack port controller: command op codes,
// controller FSM states and default sizing.
package stack_ctrl_pkg;

   localparam int DW_DEFAULT    = 8;
   localparam int DEPTH_DEFAULT = 255;
   localparam int CW_DEFAULT    = 8;

   typedef enum logic [1:0] {
      OP_ILL  = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_TOP  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ISSUE   = 2'b01,
      S_CAPTURE = 2'b10,
      S_RESP    = 2'b11
   } state_t;

endpackage

// File: rtl/stack_occ_counter.sv
// Occupancy counter for the stack controller. Counts entries held in the
// stack; the controller's error checks keep it within 0..DEPTH so it never
// wraps.
module stack_occ_counter
   import stack_ctrl_pkg::*;
#(
   parameter int CW    = CW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   logic [CW-1:0] r_count;

   // Up/down count; simultaneous inc and dec cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && !dec) begin
         r_count <= r_count + 1'b1;
      end else if (dec && !inc) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign count = r_count;
   assign empty = (r_count == '0);
   assign full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/stack_port_ctrl.sv
// Requester-side master for the LIFO stack. Accepts one PUSH/POP/TOP per
// request handshake, drives a single-cycle strobe to the stack, captures the
// stack's registered read data and returns it on the response channel.
// Overflow, underflow and illegal ops are answered without touching the stack.
module stack_port_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int DW    = DW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int CW    = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [DW-1:0] req_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic          stk_push,
   output logic          stk_pop,
   output logic          stk_top,
   output logic [DW-1:0] stk_din,
   input  logic [DW-1:0] stk_dout,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   state_t        r_state;
   op_t           r_op;
   logic          r_reqReady;
   logic          r_rspValid;
   logic [DW-1:0] r_rspData;
   logic          r_rspErr;
   logic          r_stkPush;
   logic          r_stkPop;
   logic          r_stkTop;
   logic [DW-1:0] r_stkDin;

   op_t           w_opIn;
   logic          w_reqErr;
   logic          w_inc;
   logic          w_dec;
   logic          w_empty;
   logic          w_full;

   // Occupancy moves on the edge that closes the strobe cycle, i.e. when the
   // stack itself acts on the command.
   assign w_inc = (r_state == S_ISSUE) && (r_op == OP_PUSH);
   assign w_dec = (r_state == S_ISSUE) && (r_op == OP_POP);

   stack_occ_counter #(
      .CW    (CW),
      .DEPTH (DEPTH)
   ) u_occ (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc),
      .dec   (w_dec),
      .count (count),
      .empty (w_empty),
      .full  (w_full)
   );

   // Decide at accept time whether the incoming command can reach the stack.
   always_comb begin
      w_opIn   = op_t'(req_op);
      w_reqErr = 1'b0;
      case (w_opIn)
         OP_PUSH:        w_reqErr = w_full;
         OP_POP, OP_TOP: w_reqErr = w_empty;
         default:        w_reqErr = 1'b1;
      endcase
   end

   // Controller FSM with registered strobes and response; strobes default low
   // so each one is high for exactly the ISSUE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= OP_ILL;
         r_reqReady <= 1'b1;
         r_rspValid <= 1'b0;
         r_rspData  <= '0;
         r_rspErr   <= 1'b0;
         r_stkPush  <= 1'b0;
         r_stkPop   <= 1'b0;
         r_stkTop   <= 1'b0;
         r_stkDin   <= '0;
      end else begin
         r_stkPush <= 1'b0;
         r_stkPop  <= 1'b0;
         r_stkTop  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid && r_reqReady) begin
                  r_reqReady <= 1'b0;
                  r_op       <= w_opIn;
                  if (w_reqErr) begin
                     r_rspErr   <= 1'b1;
                     r_rspData  <= '0;
                     r_rspValid <= 1'b1;
                     r_state    <= S_RESP;
                  end else begin
                     case (w_opIn)
                        OP_PUSH: begin
                           r_stkPush <= 1'b1;
                           r_stkDin  <= req_data;
                        end
                        OP_POP:  r_stkPop <= 1'b1;
                        default: r_stkTop <= 1'b1;
                     endcase
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_rspData  <= ((r_op == OP_POP) || (r_op == OP_TOP)) ? stk_dout : '0;
               r_rspErr   <= 1'b0;
               r_rspValid <= 1'b1;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_reqReady <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_reqReady <= 1'b1;
               r_rspValid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_reqReady;
   assign rsp_valid = r_rspValid;
   assign rsp_data  = r_rspData;
   assign rsp_err   = r_rspErr;
   assign stk_push  = r_stkPush;
   assign stk_pop   = r_stkPop;
   assign stk_top   = r_stkTop;
   assign stk_din   = r_stkDin;
   assign empty     = w_empty;
   assign full      = w_full;

endmodule

// File: tb/tb_stack_port_ctrl.sv
// Bench for stack_port_ctrl with a behavioural 256x8 pre-increment stack on
// the same clk/rst. Directed table, fill-to-full, reset-in-flight and random
// commands against a queue-based reference model.
module tb_stack_port_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [7:0] req_data = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       stk_push;
   logic       stk_pop;
   logic       stk_top;
   logic [7:0] stk_din;
   logic [7:0] stk_dout;
   logic [7:0] count;
   logic       empty;
   logic       full;

   int checks = 0;
   int passes = 0;

   int pushPulses = 0;
   int popPulses  = 0;
   int topPulses  = 0;
   int strobeViol = 0;
   logic prevStrobe = 1'b0;

   logic [7:0] refStack [$];

   typedef struct {
      logic [1:0] op;
      logic [7:0] data;
      int         rdyDelay;
      logic [7:0] expData;
      logic       expErr;
      logic [7:0] expCount;
   } vec_t;

   vec_t vecs [13];

   stack_port_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_top   (stk_top),
      .stk_din   (stk_din),
      .stk_dout  (stk_dout),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   always #5 clk = ~clk;

   // Behavioural stack: pre-increment push, registered read data.
   logic [7:0] stkMem [256];
   logic [7:0] stkPtr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stkPtr   <= 8'd0;
         stk_dout <= 8'd0;
      end else if (stk_push) begin
         stkPtr <= stkPtr + 8'd1;
      end else if (stk_pop) begin
         stk_dout <= stkMem[stkPtr];
         stkPtr   <= stkPtr - 8'd1;
      end else if (stk_top) begin
         stk_dout <= stkMem[stkPtr];
      end
   end

   always @(posedge clk) begin
      if (!rst && stk_push) stkMem[stkPtr + 8'd1] <= stk_din;
   end

   // Count strobe pulses seen by the stack and flag overlapping or stretched strobes.
   always @(posedge clk) begin
      if (!rst) begin
         if (stk_push) pushPulses++;
         if (stk_pop)  popPulses++;
         if (stk_top)  topPulses++;
         if ((32'(stk_push) + 32'(stk_pop) + 32'(stk_top)) > 1) strobeViol++;
         if (prevStrobe && (stk_push || stk_pop || stk_top)) strobeViol++;
         prevStrobe = stk_push || stk_pop || stk_top;
      end else begin
         prevStrobe = 1'b0;
      end
   end

   // Runaway guard.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running, want done");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
   endtask

   task automatic modelCmd(input logic [1:0] op, input logic [7:0] data,
                           output logic [7:0] expData, output logic expErr);
      expData = 8'h00;
      expErr  = 1'b0;
      case (op)
         2'b01: if (refStack.size() >= 255) expErr = 1'b1; else refStack.push_back(data);
         2'b10: if (refStack.size() == 0) expErr = 1'b1; else expData = refStack.pop_back();
         2'b11: if (refStack.size() == 0) expErr = 1'b1; else expData = refStack[$];
         default: expErr = 1'b1;
      endcase
   endtask

   task automatic doReset();
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      refStack.delete();
   endtask

   // One full command/response transaction; reports what the DUT did.
   task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data, input int rdyDelay,
                                output logic [7:0] obsData, output logic obsErr,
                                output int obsLat, output logic [5:0] obsStrobes);
      int waitN;
      int p0, q0, t0;
      logic holdOk;
      logic [9:0] snap;
      obsData = 8'h00;
      obsErr = 1'b0;
      obsLat = -1;
      obsStrobes = 6'h3f;
      waitN = 0;
      while (req_ready !== 1'b1 && waitN < 10) begin
         @(negedge clk);
         waitN++;
      end
      if (req_ready !== 1'b1) begin
         checkOutput("reqReadyTimeout", 32'(req_ready), 32'd1);
         return;
      end
      p0 = pushPulses;
      q0 = popPulses;
      t0 = topPulses;
      req_valid = 1'b1;
      req_op = op;
      req_data = data;
      @(negedge clk);
      req_valid = 1'b0;
      req_op = 2'($urandom);
      req_data = 8'($urandom);
      obsLat = 0;
      while (rsp_valid !== 1'b1 && obsLat < 8) begin
         @(negedge clk);
         obsLat++;
      end
      if (rsp_valid !== 1'b1) begin
         checkOutput("rspTimeout", 32'(rsp_valid), 32'd1);
         return;
      end
      checkOutput("busyReady", 32'(req_ready), 32'd0);
      snap = {rsp_err, rsp_valid, rsp_data};
      holdOk = 1'b1;
      for (int i = 0; i < rdyDelay; i++) begin
         @(negedge clk);
         if ({rsp_err, rsp_valid, rsp_data} !== snap || req_ready !== 1'b0) holdOk = 1'b0;
      end
      if (rdyDelay > 0) checkOutput("rspHold", 32'(holdOk), 32'd1);
      obsData = rsp_data;
      obsErr = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("rspDrop", 32'({rsp_valid, req_ready}), 32'b01);
      obsStrobes = {2'(pushPulses - p0), 2'(popPulses - q0), 2'(topPulses - t0)};
   endtask

   task automatic runCheck(input string tag, input logic [1:0] op, input logic [7:0] data,
                           input int rdyDelay, input logic [7:0] expData, input logic expErr,
                           input logic [7:0] expCount);
      logic [7:0] obsData;
      logic       obsErr;
      int         obsLat;
      logic [5:0] obsStrobes;
      logic [5:0] expStrobes;
      applyStimulus(op, data, rdyDelay, obsData, obsErr, obsLat, obsStrobes);
      if (expErr) expStrobes = 6'b000000;
      else if (op == 2'b01) expStrobes = 6'b010000;
      else if (op == 2'b10) expStrobes = 6'b000100;
      else expStrobes = 6'b000001;
      checkOutput({tag, ".data"}, 32'(obsData), 32'(expData));
      checkOutput({tag, ".err"}, 32'(obsErr), 32'(expErr));
      checkOutput({tag, ".latency"}, 32'(obsLat), expErr ? 32'd0 : 32'd2);
      checkOutput({tag, ".strobes"}, 32'(obsStrobes), 32'(expStrobes));
      checkOutput({tag, ".count"}, 32'(count), 32'(expCount));
      checkOutput({tag, ".flags"}, 32'({empty, full}), 32'({expCount == 8'd0, expCount == 8'd255}));
   endtask

   initial begin
      logic [7:0] ed;
      logic       ee;
      logic [1:0] op;
      int         r;
      int         p0;

      vecs[0]  = '{2'b10, 8'h00, 0, 8'h00, 1'b1, 8'd0};
      vecs[1]  = '{2'b11, 8'h00, 0, 8'h00, 1'b1, 8'd0};
      vecs[2]  = '{2'b00, 8'h77, 2, 8'h00, 1'b1, 8'd0};
      vecs[3]  = '{2'b01, 8'h11, 0, 8'h00, 1'b0, 8'd1};
      vecs[4]  = '{2'b01, 8'h22, 0, 8'h00, 1'b0, 8'd2};
      vecs[5]  = '{2'b01, 8'h33, 1, 8'h00, 1'b0, 8'd3};
      vecs[6]  = '{2'b10, 8'h00, 5, 8'h33, 1'b0, 8'd2};
      vecs[7]  = '{2'b10, 8'h00, 0, 8'h22, 1'b0, 8'd1};
      vecs[8]  = '{2'b10, 8'h00, 0, 8'h11, 1'b0, 8'd0};
      vecs[9]  = '{2'b01, 8'hA5, 0, 8'h00, 1'b0, 8'd1};
      vecs[10] = '{2'b11, 8'h00, 0, 8'hA5, 1'b0, 8'd1};
      vecs[11] = '{2'b11, 8'h00, 3, 8'hA5, 1'b0, 8'd1};
      vecs[12] = '{2'b10, 8'h00, 0, 8'hA5, 1'b0, 8'd0};

      #2;
      doReset();
      $display("[TB] reset state");
      checkOutput("rstFlags", 32'({req_ready, rsp_valid, rsp_err, stk_push, stk_pop, stk_top, empty, full}),
                  32'b10000010);
      checkOutput("rstData", 32'({rsp_data, stk_din}), 32'd0);
      checkOutput("rstCount", 32'(count), 32'd0);

      $display("[TB] directed table");
      for (int i = 0; i < 13; i++) begin
         runCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].rdyDelay,
                  vecs[i].expData, vecs[i].expErr, vecs[i].expCount);
      end

      $display("[TB] fill to full");
      doReset();
      for (int i = 1; i <= 255; i++) begin
         runCheck("fill", 2'b01, 8'(i), 0, 8'h00, 1'b0, 8'(i));
      end
      runCheck("overflow", 2'b01, 8'h5C, 1, 8'h00, 1'b1, 8'd255);
      runCheck("popAfterFull", 2'b10, 8'h00, 0, 8'hFF, 1'b0, 8'd254);

      $display("[TB] reset during ISSUE");
      p0 = pushPulses;
      req_valid = 1'b1;
      req_op = 2'b01;
      req_data = 8'h5A;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("issueStrobe", 32'(stk_push), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midRstState", 32'({count, empty, stk_push, stk_pop, stk_top, rsp_valid, req_ready}),
                  32'({8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
      rst = 1'b0;
      refStack.delete();
      repeat (3) @(negedge clk);
      checkOutput("midRstNoRsp", 32'({rsp_valid, count}), 32'd0);
      checkOutput("midRstNoPush", 32'(pushPulses - p0), 32'd0);
      runCheck("popAfterRst", 2'b10, 8'h00, 0, 8'h00, 1'b1, 8'd0);

      $display("[TB] random commands");
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if (r < 50) op = 2'b01;
         else if (r < 78) op = 2'b10;
         else if (r < 95) op = 2'b11;
         else op = 2'b00;
         req_data = 8'($urandom);
         modelCmd(op, req_data, ed, ee);
         runCheck("rnd", op, req_data, $urandom_range(0, 3), ed, ee, 8'(refStack.size()));
      end

      checkOutput("strobeShape", 32'(strobeViol), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
